// File: rtl/receiver_pkg.sv
// Shared switch definitions: flit bus sizing, index widths and the
// receiver handshake state encoding.
package receiver_pkg;

    // IDLE/ACK are one-hot so any corrupted encoding is detectable.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_ACK  = 2'b10
    } rx_state_t;

    // Flit bus: payload + destination address + one control bit.
    function automatic int bus_size(input int data_size, input int addr_size);
        return data_size + addr_size + 1;
    endfunction

    // Width of an index able to address n items (never narrower than 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first requesting port after 'last',
// wrapping modulo N.
module rr_arbiter
    import receiver_pkg::*;
#(
    parameter  int N  = 5,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          any
);

    int w_idx;

    // Scan from farthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        grant = last;
        any   = 1'b0;
        w_idx = 0;
        for (int k = N; k >= 1; k--) begin
            w_idx = (int'(last) + k) % N;
            if (req[IW'(w_idx)]) begin
                grant = IW'(w_idx);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/receiver.sv
// Switch input receiver: arbitrates among PORTS_NUM+1 four-phase senders,
// writes one flit per handshake into the local queue, counts flits and
// flags senders that fail to release their request in time.
module receiver
    import receiver_pkg::*;
#(
    parameter  int DATA_SIZE = 32,
    parameter  int ADDR_SIZE = 4,
    parameter  int PORTS_NUM = 4,
    parameter  int TIMEOUT   = 16,
    localparam int BUS_SIZE  = bus_size(DATA_SIZE, ADDR_SIZE)
) (
    input  logic                              clk,
    input  logic                              a_rst,
    input  logic [PORTS_NUM:0]                wr_ready_in,
    input  logic [BUS_SIZE*(PORTS_NUM+1)-1:0] data_i,
    input  logic                              mem_full,
    output logic [PORTS_NUM:0]                r_ready_out,
    output logic                              mem_wr,
    output logic [BUS_SIZE-1:0]               data_o,
    output logic [15:0]                       flit_cnt,
    output logic                              err_timeout
);

    localparam int NP     = PORTS_NUM + 1;
    localparam int IW     = idx_width(NP);
    localparam int WAIT_W = idx_width(TIMEOUT);

    rx_state_t            r_state, w_state_nxt;
    logic [IW-1:0]        r_port, w_port_nxt;
    logic [IW-1:0]        r_last, w_last_nxt;
    logic [WAIT_W-1:0]    r_wait, w_wait_nxt;
    logic [NP-1:0]        r_ack, w_ack_nxt;
    logic                 r_wr, w_wr_nxt;
    logic [BUS_SIZE-1:0]  r_data, w_data_nxt;
    logic [15:0]          r_cnt, w_cnt_nxt;
    logic                 r_err, w_err_nxt;

    logic [NP-1:0]        w_req;
    logic [IW-1:0]        w_grant;
    logic                 w_any;

    // Only a solid 1 is a request; floating or unknown inputs are ignored.
    for (genvar p = 0; p < NP; p++) begin : g_req
        assign w_req[p] = (wr_ready_in[p] === 1'b1);
    end

    rr_arbiter #(.N(NP)) u_arb (
        .req   (w_req),
        .last  (r_last),
        .grant (w_grant),
        .any   (w_any)
    );

    // Next-state and output logic of the handshake FSM.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_port_nxt  = r_port;
        w_last_nxt  = r_last;
        w_wait_nxt  = r_wait;
        w_ack_nxt   = r_ack;
        w_wr_nxt    = 1'b0;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        case (r_state)
            ST_IDLE: begin
                w_ack_nxt  = '0;
                w_wait_nxt = '0;
                if (!mem_full && w_any) begin
                    w_state_nxt        = ST_ACK;
                    w_port_nxt         = w_grant;
                    w_ack_nxt[w_grant] = 1'b1;
                    w_wr_nxt           = 1'b1;
                    w_data_nxt         = data_i[int'(w_grant)*BUS_SIZE +: BUS_SIZE];
                    w_cnt_nxt          = r_cnt + 16'd1;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_ACK;
                if (!w_req[r_port] || (r_wait == WAIT_W'(TIMEOUT - 1))) begin
                    // Sender released (or ran out of time): drop ack, rotate priority.
                    w_state_nxt = ST_IDLE;
                    w_ack_nxt   = '0;
                    w_wait_nxt  = '0;
                    w_last_nxt  = r_port;
                    if (w_req[r_port]) begin
                        w_err_nxt = 1'b1;
                    end
                end else begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ack_nxt   = '0;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // State and output registers; reset abandons any handshake in flight.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            r_state <= ST_IDLE;
            r_port  <= '0;
            r_last  <= IW'(PORTS_NUM);
            r_wait  <= '0;
            r_ack   <= '0;
            r_wr    <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_port  <= w_port_nxt;
            r_last  <= w_last_nxt;
            r_wait  <= w_wait_nxt;
            r_ack   <= w_ack_nxt;
            r_wr    <= w_wr_nxt;
            r_data  <= w_data_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign r_ready_out = r_ack;
    assign mem_wr      = r_wr;
    assign data_o      = r_data;
    assign flit_cnt    = r_cnt;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: directed handshake scenarios plus
// randomized four-phase traffic against a protocol-level reference model.
module tb_receiver;

    localparam int DATA_SIZE = 32;
    localparam int ADDR_SIZE = 4;
    localparam int PORTS_NUM = 4;
    localparam int TIMEOUT   = 16;
    localparam int BUS       = DATA_SIZE + ADDR_SIZE + 1;
    localparam int NP        = PORTS_NUM + 1;

    logic              clk = 1'b0;
    logic              a_rst;
    logic [NP-1:0]     wr_ready_in;
    logic [BUS*NP-1:0] data_i;
    logic              mem_full;
    logic [NP-1:0]     r_ready_out;
    logic              mem_wr;
    logic [BUS-1:0]    data_o;
    logic [15:0]       flit_cnt;
    logic              err_timeout;

    int n_cmp  = 0;
    int n_bad  = 0;
    int exp_cnt = 0;
    int m_last  = NP - 1;
    logic [BUS-1:0] flit_data [NP];
    int grant_log[$];

    always #5 clk = ~clk;

    receiver #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE),
        .PORTS_NUM (PORTS_NUM),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .a_rst       (a_rst),
        .wr_ready_in (wr_ready_in),
        .data_i      (data_i),
        .mem_full    (mem_full),
        .r_ready_out (r_ready_out),
        .mem_wr      (mem_wr),
        .data_o      (data_o),
        .flit_cnt    (flit_cnt),
        .err_timeout (err_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_data();
        for (int p = 0; p < NP; p++) data_i[p*BUS +: BUS] = flit_data[p];
    endtask

    task automatic do_reset();
        a_rst = 1'b1;
        wr_ready_in = '0;
        mem_full = 1'b0;
        step();
        step();
        a_rst = 1'b0;
        exp_cnt = 0;
        m_last = NP - 1;
    endtask

    task automatic test_reset();
        a_rst = 1'b1;
        wr_ready_in = '0;
        mem_full = 1'b0;
        for (int p = 0; p < NP; p++) flit_data[p] = '0;
        pack_data();
        #2;
        n_cmp++; if (r_ready_out !== '0) $display("FAIL reset_ack: got %b want 0", r_ready_out);
        else n_cmp += 0;
        if (r_ready_out !== '0) n_bad++;
        n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL reset_wr: got %b want 0", mem_wr); end
        n_cmp++; if (data_o !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", data_o); end
        n_cmp++; if (flit_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", flit_cnt); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_timeout); end
        step();
        a_rst = 1'b0;
        exp_cnt = 0;
        m_last = NP - 1;
        step();
        n_cmp++; if (r_ready_out !== '0 || mem_wr !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle: got ack=%b wr=%b want 0/0", r_ready_out, mem_wr);
        end
    endtask

    task automatic test_single();
        flit_data[2] = BUS'(37'h1234);
        pack_data();
        wr_ready_in = 5'b00100;
        step();
        exp_cnt++;
        m_last = 2;
        n_cmp++; if (r_ready_out !== 5'b00100) begin n_bad++; $display("FAIL single_ack: got %b want 00100", r_ready_out); end
        n_cmp++; if (mem_wr !== 1'b1) begin n_bad++; $display("FAIL single_wr: got %b want 1", mem_wr); end
        n_cmp++; if (data_o !== BUS'(37'h1234)) begin n_bad++; $display("FAIL single_data: got %h want 1234", data_o); end
        n_cmp++; if (flit_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL single_cnt: got %0d want %0d", flit_cnt, exp_cnt); end
        step();
        n_cmp++; if (mem_wr !== 1'b0 || r_ready_out !== 5'b00100) begin
            n_bad++; $display("FAIL single_hold: got wr=%b ack=%b want 0/00100", mem_wr, r_ready_out);
        end
        n_cmp++; if (data_o !== BUS'(37'h1234)) begin n_bad++; $display("FAIL single_data_hold: got %h want 1234", data_o); end
        wr_ready_in = '0;
        step();
        n_cmp++; if (r_ready_out !== '0) begin n_bad++; $display("FAIL single_release: got %b want 0", r_ready_out); end
    endtask

    task automatic test_mem_full();
        flit_data[1] = BUS'({$urandom(), $urandom()});
        pack_data();
        mem_full = 1'b1;
        wr_ready_in = 5'b00010;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (r_ready_out !== '0 || mem_wr !== 1'b0) begin
                n_bad++; $display("FAIL full_hold: got ack=%b wr=%b want 0/0", r_ready_out, mem_wr);
            end
        end
        mem_full = 1'b0;
        step();
        exp_cnt++;
        m_last = 1;
        n_cmp++; if (r_ready_out !== 5'b00010 || mem_wr !== 1'b1) begin
            n_bad++; $display("FAIL full_grant: got ack=%b wr=%b want 00010/1", r_ready_out, mem_wr);
        end
        n_cmp++; if (data_o !== flit_data[1]) begin n_bad++; $display("FAIL full_data: got %h want %h", data_o, flit_data[1]); end
        n_cmp++; if (flit_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL full_cnt: got %0d want %0d", flit_cnt, exp_cnt); end
        wr_ready_in = '0;
        step();
    endtask

    // Four-phase senders on the ports in mask; model tracks which port holds
    // the ack and which pending port round-robin must pick next.
    task automatic run_traffic(input logic [NP-1:0] mask, input int flits, input int raise_pct,
                               input int full_pct, input int budget, input string tag);
        int remaining[NP];
        int expect_total, total, busy, g, cyc, q;
        logic [NP-1:0] pv, exp_ack;
        logic pf, grant;
        busy = -1; total = 0; expect_total = 0; cyc = 0;
        for (int p = 0; p < NP; p++) begin
            remaining[p] = mask[p] ? flits : 0;
            expect_total += remaining[p];
        end
        grant_log.delete();
        wr_ready_in = '0;
        mem_full = 1'b0;
        while (cyc < budget && !(total == expect_total && busy < 0 && wr_ready_in == '0)) begin
            pv = wr_ready_in;
            pf = mem_full;
            step();
            cyc++;
            grant = 1'b0;
            g = -1;
            if (busy >= 0) begin
                if (!pv[busy]) busy = -1;
            end else if (!pf && pv != '0) begin
                for (int k = 1; k <= NP; k++) begin
                    q = (m_last + k) % NP;
                    if (g < 0 && pv[q]) g = q;
                end
                busy = g; m_last = g; grant = 1'b1;
                exp_cnt = (exp_cnt + 1) % 65536;
                total++;
                remaining[g]--;
            end
            exp_ack = '0;
            if (busy >= 0) exp_ack[busy] = 1'b1;
            n_cmp++; if (r_ready_out !== exp_ack) begin
                n_bad++; $display("FAIL %s_ack: cycle %0d got %b want %b", tag, cyc, r_ready_out, exp_ack);
            end
            n_cmp++; if (mem_wr !== grant) begin
                n_bad++; $display("FAIL %s_wr: cycle %0d got %b want %b", tag, cyc, mem_wr, grant);
            end
            if (grant) begin
                grant_log.push_back(g);
                n_cmp++; if (data_o !== flit_data[g]) begin
                    n_bad++; $display("FAIL %s_data: port %0d got %h want %h", tag, g, data_o, flit_data[g]);
                end
                n_cmp++; if (flit_cnt !== 16'(exp_cnt)) begin
                    n_bad++; $display("FAIL %s_cnt: got %0d want %0d", tag, flit_cnt, exp_cnt);
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (wr_ready_in[p] && r_ready_out[p]) wr_ready_in[p] = 1'b0;
                else if (!wr_ready_in[p] && !r_ready_out[p] && remaining[p] > 0 &&
                         $urandom_range(99) < raise_pct) begin
                    flit_data[p] = BUS'({$urandom(), $urandom()});
                    wr_ready_in[p] = 1'b1;
                end
            end
            mem_full = ($urandom_range(99) < full_pct);
            pack_data();
        end
        n_cmp++; if (total != expect_total || busy >= 0) begin
            n_bad++; $display("FAIL %s_drain: delivered %0d want %0d within %0d cycles", tag, total, expect_total, budget);
        end
        wr_ready_in = '0;
        mem_full = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        int exp_order[6] = '{0, 1, 3, 0, 1, 3};
        do_reset();
        run_traffic(5'b01011, 2, 100, 0, 200, "rr");
        n_cmp++; if (grant_log.size() != 6) begin
            n_bad++; $display("FAIL rr_count: got %0d want 6", grant_log.size());
        end
        for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
            n_cmp++; if (grant_log[i] != exp_order[i]) begin
                n_bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, grant_log[i], exp_order[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [NP-1:0] mask;
        for (int it = 0; it < 3; it++) begin
            mask = NP'($urandom_range(1, (1 << NP) - 1));
            run_traffic(mask, 4, 60, 20, 2000, "rand");
        end
    endtask

    task automatic test_timeout();
        flit_data[0] = BUS'({$urandom(), $urandom()});
        pack_data();
        wr_ready_in = 5'b00001;
        step();
        exp_cnt++;
        m_last = 0;
        n_cmp++; if (r_ready_out !== 5'b00001 || mem_wr !== 1'b1) begin
            n_bad++; $display("FAIL to_grant: got ack=%b wr=%b want 00001/1", r_ready_out, mem_wr);
        end
        for (int i = 1; i < TIMEOUT; i++) begin
            step();
            n_cmp++; if (r_ready_out !== 5'b00001 || err_timeout !== 1'b0) begin
                n_bad++; $display("FAIL to_wait: cycle %0d got ack=%b err=%b want 00001/0", i, r_ready_out, err_timeout);
            end
        end
        step();
        n_cmp++; if (r_ready_out !== '0 || err_timeout !== 1'b1) begin
            n_bad++; $display("FAIL to_release: got ack=%b err=%b want 0/1", r_ready_out, err_timeout);
        end
        wr_ready_in = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (err_timeout !== 1'b1) begin
                n_bad++; $display("FAIL to_sticky: got %b want 1", err_timeout);
            end
        end
    endtask

    task automatic test_z_and_reset();
        flit_data[0] = BUS'({$urandom(), $urandom()});
        flit_data[4] = BUS'({$urandom(), $urandom()});
        pack_data();
        wr_ready_in = '0;
        wr_ready_in[4] = 1'bz;
        wr_ready_in[0] = 1'b1;
        step();
        exp_cnt++;
        n_cmp++; if (r_ready_out !== 5'b00001 || mem_wr !== 1'b1) begin
            n_bad++; $display("FAIL z_grant: got ack=%b wr=%b want 00001/1", r_ready_out, mem_wr);
        end
        a_rst = 1'b1;
        #1;
        n_cmp++; if (r_ready_out !== '0 || mem_wr !== 1'b0) begin
            n_bad++; $display("FAIL rst_ack: got ack=%b wr=%b want 0/0", r_ready_out, mem_wr);
        end
        n_cmp++; if (data_o !== '0 || flit_cnt !== 16'd0 || err_timeout !== 1'b0) begin
            n_bad++; $display("FAIL rst_state: got data=%h cnt=%0d err=%b want 0/0/0", data_o, flit_cnt, err_timeout);
        end
        step();
        a_rst = 1'b0;
        exp_cnt = 0;
        m_last = NP - 1;
        step();
        exp_cnt++;
        m_last = 0;
        n_cmp++; if (r_ready_out !== 5'b00001 || mem_wr !== 1'b1) begin
            n_bad++; $display("FAIL rst_regrant: got ack=%b wr=%b want 00001/1", r_ready_out, mem_wr);
        end
        n_cmp++; if (flit_cnt !== 16'(exp_cnt) || data_o !== flit_data[0]) begin
            n_bad++; $display("FAIL rst_regrant_data: got cnt=%0d data=%h want %0d/%h", flit_cnt, data_o, exp_cnt, flit_data[0]);
        end
        wr_ready_in = '0;
        step();
        n_cmp++; if (r_ready_out !== '0) begin
            n_bad++; $display("FAIL rst_release: got %b want 0", r_ready_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mem_full();
        test_round_robin();
        test_random();
        test_timeout();
        test_z_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter DATA_SIZE, default 32, flit payload width.
REQ-002 Parameter ADDR_SIZE, default 4, destination address field width.
REQ-003 Parameter PORTS_NUM, default 4, number of external ports; port index PORTS_NUM is the local port.
REQ-004 Parameter TIMEOUT, default 16, cycles allowed for the sender to release its request after acknowledge.
REQ-005 Localparam BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 a_rst  input  1  reset, asynchronous, active-high.
REQ-008 wr_ready_in  input  PORTS_NUM+1  per-port flit-valid from upstream senders.
REQ-009 data_i  input  BUS_SIZE*(PORTS_NUM+1)  per-port flit; port p occupies bits [p*BUS_SIZE +: BUS_SIZE].
REQ-010 mem_full  input  1  local queue cannot accept a flit.
REQ-011 r_ready_out  output  PORTS_NUM+1  per-port acknowledge to the sender.
REQ-012 mem_wr  output  1  single-cycle queue write strobe.
REQ-013 data_o  output  BUS_SIZE  flit to the queue, valid while mem_wr=1 and held until the next capture.
REQ-014 flit_cnt  output  16  count of accepted flits.
REQ-015 err_timeout  output  1  sticky flag set on any handshake timeout.

Function
REQ-016 A port requests only when wr_ready_in[p] is exactly 1; z or x SHALL be treated as no request, so unconnected ports are ignored.
REQ-017 The FSM SHALL have the states IDLE and ACK; any other encoding SHALL return to IDLE.
REQ-018 IDLE with mem_full=0 and at least one request SHALL grant one port by round-robin, searching from last_port+1 modulo PORTS_NUM+1.
REQ-019 On a grant, the same edge SHALL load data_o from the granted slice, set mem_wr=1 and r_ready_out[g]=1, latch port_r=g, and enter ACK; latency from a visible request to ack is 1 cycle.
REQ-020 IDLE with mem_full=1 SHALL grant nothing; all requests are held off with no ack and no write.
REQ-021 In ACK, mem_wr SHALL be 0 at every edge, so each flit produces exactly one write pulse.
REQ-022 In ACK, when wr_ready_in[port_r] is not exactly 1, the receiver SHALL clear r_ready_out[port_r], set last_port=port_r, and return to IDLE.
REQ-023 In ACK, the wait counter SHALL increment each cycle; at TIMEOUT cycles the receiver SHALL release as in REQ-022 and set err_timeout=1.
REQ-024 At most one r_ready_out bit SHALL be high at any time.
REQ-025 flit_cnt SHALL increment by 1 per grant and wrap from 0xFFFF to 0.
REQ-026 Four-phase order: sender raises valid, receiver acks, sender drops valid, receiver drops ack; a new flit on the same port is accepted no earlier than the edge after the ack drops.
REQ-027 Requests on other ports during ACK SHALL wait; none are lost while their wr_ready_in stays high.

Reset
REQ-028 While a_rst=1: state=IDLE, r_ready_out=0, mem_wr=0, data_o=0, flit_cnt=0, err_timeout=0, wait counter=0, last_port=PORTS_NUM (port 0 has first priority).
REQ-029 Reset during ACK SHALL abandon the handshake; a sender still holding its request SHALL be re-accepted after reset.

Structure
REQ-030 The shared switch package SHALL hold the BUS_SIZE computation and the IDLE/ACK state encoding.
REQ-031 The round-robin selection SHALL be a sub-module rr_arbiter (inputs req, last; outputs grant index, any).

Verification
REQ-032 Single flit on port 2 with data 0x1234, mem_full=0 -> r_ready_out=5'b00100 and one mem_wr pulse 1 cycle later; data_o=0x1234; flit_cnt=1.
REQ-033 Ports 0, 1 and 3 requesting continuously -> grants in order 0, 1, 3, 0, 1, 3.
REQ-034 mem_full=1 with port 1 requesting -> no ack and no write; after mem_full drops, grant on the next edge.
REQ-035 Sender holds valid 16 cycles after ack -> release at cycle 16 and err_timeout=1 until reset.
REQ-036 Port 4 driven z, port 0 valid -> only port 0 granted; a_rst pulse during ACK -> all outputs 0, then port 0 re-granted.
